// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, data-bus access FSM, load/store lane formatting, WB register.
// Latency: one cycle EX->WB for zero-wait acks; each cycle without mem_ack adds one stall cycle.
// Backpressure: Stall holds upstream and this stage while ACCESS waits; aborts after MAX_WAIT cycles.
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_ALUOut,
  input  logic [31:0] EX_WrData,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_RegDest,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic [1:0]  EX_MemtoReg,
  input  logic [1:0]  EX_Size,
  input  logic        EX_LoadSign,
  input  logic        Flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        Stall,
  output logic [31:0] MEM_Fwd,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_RegDest,
  output logic [31:0] WB_Data,
  output logic        MemErr
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] wr_data;
    logic        reg_write;
    logic [4:0]  reg_dest;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  memto_reg;
    logic [1:0]  size;
    logic        load_sign;
  } exmem_t;

  // Size encoding: 10 byte, 01 half, anything else handled as a word.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      2'b10:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

  state_t        state, state_nxt;
  exmem_t        r;
  logic [CW-1:0] wait_cnt;
  logic          in_access, in_mem_op, abort, misalign_r, err;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_data;

  assign in_access  = (state == ACCESS);
  assign in_mem_op  = (EX_MemRead | EX_MemWrite) & ~Flush & ~misaligned(EX_ALUOut[1:0], EX_Size);
  assign abort      = in_access & ~mem_ack & (wait_cnt == LAST);
  assign misalign_r = (r.mem_read | r.mem_write) & misaligned(r.alu_out[1:0], r.size);
  assign err        = misalign_r | abort;

  assign mem_addr = {r.alu_out[31:2], 2'b00};
  assign mem_we   = r.mem_write;
  assign MEM_Fwd  = r.alu_out;

  // FSM next state and bus handshake outputs; Stall drops on ack or on the abort cycle.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    Stall     = 1'b0;
    if (in_access) begin
      mem_req = 1'b1;
      Stall   = ~mem_ack & ~abort;
    end
    if (!Stall) state_nxt = in_mem_op ? ACCESS : IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Count unacknowledged ACCESS cycles; restarts whenever the stage advances.
  always_ff @(posedge clk) begin
    if (reset || !Stall) wait_cnt <= '0;
    else                 wait_cnt <= wait_cnt + CW'(1);
  end

  // EX/MEM register; Flush only takes effect on an advancing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
    end else if (!Stall) begin
      r.alu_out   <= EX_ALUOut;
      r.wr_data   <= EX_WrData;
      r.reg_write <= EX_RegWrite & ~Flush;
      r.reg_dest  <= EX_RegDest;
      r.mem_read  <= EX_MemRead & ~Flush;
      r.mem_write <= EX_MemWrite & ~Flush;
      r.memto_reg <= EX_MemtoReg;
      r.size      <= EX_Size;
      r.load_sign <= EX_LoadSign;
    end
  end

  // Store lane enables and lane-replicated write data (little-endian).
  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = r.wr_data;
    case (r.size)
      2'b10: begin
        mem_be    = 4'b0001 << r.alu_out[1:0];
        mem_wdata = {4{r.wr_data[7:0]}};
      end
      2'b01: begin
        mem_be    = r.alu_out[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{r.wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    case (r.alu_out[1:0])
      2'b00:   byte_lane = mem_rdata[7:0];
      2'b01:   byte_lane = mem_rdata[15:8];
      2'b10:   byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = r.alu_out[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r.size)
      2'b10:   load_data = {{24{r.load_sign & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{r.load_sign & half_lane[15]}}, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  // WB register; MemErr is cleared on stalled edges so it stays a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      WB_RegWrite <= 1'b0;
      WB_RegDest  <= '0;
      WB_Data     <= '0;
      MemErr      <= 1'b0;
    end else if (!Stall) begin
      WB_RegWrite <= r.reg_write & ~r.mem_write & ~err;
      WB_RegDest  <= r.reg_dest;
      WB_Data     <= (r.memto_reg == 2'b01) ? load_data : r.alu_out;
      MemErr      <= err;
    end else begin
      MemErr      <= 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15; maximum ACCESS cycles without mem_ack before abort.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port EX_ALUOut  in  32  address or ALU result from EX stage (already PC+4 for link instructions).
REQ-005 SHALL have port EX_WrData  in  32  forwarded store data from EX stage.
REQ-006 SHALL have ports EX_RegWrite in 1, EX_RegDest in 5, EX_MemRead in 1, EX_MemWrite in 1, EX_MemtoReg in 2 (01 = load data); control from EX stage.
REQ-007 SHALL have ports EX_Size in 2 (00 word, 01 half, 10 byte) and EX_LoadSign in 1 (1 = sign-extend loads).
REQ-008 SHALL have port Flush  in  1  converts the incoming instruction into a bubble.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4, mem_ack in 1, mem_rdata in 32; data bus.
REQ-010 SHALL have port Stall  out  1  freezes PC, IF/ID, ID/EX and this stage's input register.
REQ-011 SHALL have port MEM_Fwd  out  32  registered ALU result; EX-stage MEM forwarding source.
REQ-012 SHALL have ports WB_RegWrite out 1, WB_RegDest out 5, WB_Data out 32, MemErr out 1.

Function
REQ-013 SHALL hold an EX/MEM register of all EX_* inputs, loaded on each edge where Stall=0 and held where Stall=1.
REQ-014 SHALL load RegWrite/MemRead/MemWrite as 0 when Flush=1 and Stall=0; Flush SHALL be ignored while Stall=1.
REQ-015 SHALL implement FSM states IDLE and ACCESS; next state computed from incoming EX_* signals at load time.
REQ-016 SHALL enter ACCESS on a load edge whose incoming instruction is an aligned memory op with Flush=0; otherwise IDLE.
REQ-017 SHALL treat as misaligned: word with addr[1:0]!=0, half with addr[0]!=0; misaligned ops SHALL never enter ACCESS or assert mem_req.
REQ-018 SHALL drive mem_req=1 only in ACCESS; mem_addr = {addr[31:2],2'b00}; mem_we = registered MemWrite.
REQ-019 SHALL drive Stall = (state==ACCESS) & ~mem_ack, combinational from mem_ack; zero-wait ack gives one-cycle memory latency, no stall.
REQ-020 SHALL, on an edge in ACCESS with mem_ack=1, return to IDLE (or ACCESS if next instruction is also an aligned memory op) and capture WB outputs.
REQ-021 SHALL, for stores, drive mem_be little-endian: word 1111; half 0011/1100 by addr[1]; byte one-hot by addr[1:0]; mem_wdata replicates the low half/byte into every lane.
REQ-022 SHALL, for loads, select lane per addr and sign- or zero-extend per registered LoadSign; word loads pass mem_rdata unchanged.
REQ-023 SHALL count cycles in ACCESS; on the MAX_WAIT-th cycle without ack, abort to IDLE, deassert Stall that cycle, pulse MemErr, suppress WB_RegWrite.
REQ-024 SHALL pulse MemErr for one cycle and suppress WB_RegWrite for a misaligned op, written into WB on the next non-stalled edge.
REQ-025 SHALL load the WB register on every edge where Stall=0: WB_Data = formatted load if MemtoReg==01, else registered ALUOut; WB_RegWrite cleared for stores, bubbles, errors.
REQ-026 SHALL drive MEM_Fwd from registered ALUOut at all times.

Reset
REQ-027 SHALL, on reset=1 at an edge, set state IDLE, wait counter 0, all EX/MEM and WB registers 0, regardless of ACCESS in progress.
REQ-028 SHALL force mem_req=0, Stall=0, MemErr=0, WB_RegWrite=0 in the cycle after reset, and ignore mem_ack while in reset.

Verification
REQ-029 SHALL cover: lw addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> Stall high 3 cycles, WB_Data=0xDEADBEEF, WB_RegWrite=1.
REQ-030 SHALL cover: lb LoadSign=1 addr 0x103, zero-wait ack rdata 0x80123456 -> no stall, WB_Data=0xFFFFFF80; lbu gives 0x00000080.
REQ-031 SHALL cover: sh addr 0x202 data 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, WB_RegWrite=0.
REQ-032 SHALL cover: lw addr 0x101 -> no mem_req, MemErr one-cycle pulse, WB_RegWrite=0.
REQ-033 SHALL cover: no ack for MAX_WAIT=15 cycles -> abort, MemErr pulse, Stall drops, next instruction proceeds.
REQ-034 SHALL cover: reset asserted mid-ACCESS and Flush during Stall -> IDLE and zeros after reset; flushed instruction not bubbled while stalled.
